// File: rtl/vec_exec_pkg.sv
// vec_exec_pkg: opcodes, FSM states and flag indices shared by the vector execute unit
package vec_exec_pkg;
  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL1, OP_SHR1, OP_ROTL1
  } op_e;
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
endpackage

// File: rtl/vec_exec_lane.sv
// vec_exec_lane: one combinational lane ALU with carry/borrow out for ADD/SUB
module vec_exec_lane
  import vec_exec_pkg::*;
#(
  parameter int ELEM_SIZE = 8
) (
  input  logic [ELEM_SIZE-1:0] a,
  input  logic [ELEM_SIZE-1:0] b,
  input  op_e                  op,
  output logic [ELEM_SIZE-1:0] y,
  output logic                 cout
);
  logic [ELEM_SIZE:0] sum, dif;
  assign sum = {1'b0, a} + {1'b0, b};
  assign dif = {1'b0, a} - {1'b0, b};
  always_comb begin
    y = op == OP_ADD  ? sum[ELEM_SIZE-1:0] :
        op == OP_SUB  ? dif[ELEM_SIZE-1:0] :
        op == OP_AND  ? a & b :
        op == OP_OR   ? a | b :
        op == OP_XOR  ? a ^ b :
        op == OP_SHL1 ? a << 1 :
        op == OP_SHR1 ? a >> 1 :
                        {a[ELEM_SIZE-2:0], a[ELEM_SIZE-1]};
    cout = op == OP_ADD ? sum[ELEM_SIZE] : op == OP_SUB ? dif[ELEM_SIZE] : 1'b0;
  end
endmodule

// File: rtl/vec_exec_iter.sv
// vec_exec_iter: multi-cycle iterated lane-wise vector ALU / element swap behind a valid/ready handshake
module vec_exec_iter
  import vec_exec_pkg::*;
#(
  parameter int ELEM_SIZE = 8,
  parameter int VECT_SIZE = 8,
  parameter int REP_BITS  = 4,
  parameter int IDX_BITS  = $clog2(VECT_SIZE)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           in_valid_i,
  output logic                           in_ready_o,
  input  logic [2:0]                     op_i,
  input  logic [ELEM_SIZE*VECT_SIZE-1:0] vec_a_i,
  input  logic [ELEM_SIZE*VECT_SIZE-1:0] vec_b_i,
  input  logic [7:0]                     imm_i,
  input  logic                           use_imm_i,
  input  logic                           swap_en_i,
  input  logic [IDX_BITS-1:0]            swap_src_i,
  input  logic [IDX_BITS-1:0]            swap_dst_i,
  input  logic [REP_BITS-1:0]            rep_i,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output logic [ELEM_SIZE*VECT_SIZE-1:0] res_o,
  output logic [1:0]                     flags_o
);
  localparam int VW = ELEM_SIZE * VECT_SIZE;
  state_e state, state_nx;
  op_e op_q;
  logic [REP_BITS-1:0] cnt;
  logic [VW-1:0] acc, b_q, alu_y, swap_y, nxt, res_q;
  logic [VECT_SIZE-1:0] couts;
  logic [IDX_BITS-1:0] src_q, dst_q;
  logic [1:0] flags_q;
  logic swap_q, accept;
  assign accept = in_valid_i & in_ready_o;
  for (genvar i = 0; i < VECT_SIZE; i++) begin : g_lane
    vec_exec_lane #(.ELEM_SIZE(ELEM_SIZE)) u_lane (
      .a   (acc[i*ELEM_SIZE +: ELEM_SIZE]),
      .b   (b_q[i*ELEM_SIZE +: ELEM_SIZE]),
      .op  (op_q),
      .y   (alu_y[i*ELEM_SIZE +: ELEM_SIZE]),
      .cout(couts[i])
    );
    assign swap_y[i*ELEM_SIZE +: ELEM_SIZE] =
      IDX_BITS'(i) == src_q ? acc[dst_q*ELEM_SIZE +: ELEM_SIZE] :
      IDX_BITS'(i) == dst_q ? acc[src_q*ELEM_SIZE +: ELEM_SIZE] :
                              acc[i*ELEM_SIZE +: ELEM_SIZE];
  end
  assign nxt = swap_q ? swap_y : alu_y;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state <= S_IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == S_IDLE ? (accept ? S_BUSY : S_IDLE) :
               state == S_BUSY ? (cnt == '0 ? S_DONE : S_BUSY) :
                                 (out_ready_i ? S_IDLE : S_DONE);
  always_comb begin
    in_ready_o  = state == S_IDLE && !rst_i;
    out_valid_o = state == S_DONE;
    res_o       = res_q;
    flags_o     = flags_q;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc     <= '0;
      b_q     <= '0;
      op_q    <= OP_ADD;
      swap_q  <= 1'b0;
      src_q   <= '0;
      dst_q   <= '0;
      cnt     <= '0;
      res_q   <= '0;
      flags_q <= '0;
    end else if (accept) begin
      acc    <= vec_a_i;
      b_q    <= use_imm_i ? {VECT_SIZE{ELEM_SIZE'(imm_i)}} : vec_b_i;
      op_q   <= op_e'(op_i);
      swap_q <= swap_en_i;
      src_q  <= swap_src_i;
      dst_q  <= swap_dst_i;
      cnt    <= swap_en_i ? '0 : rep_i;
    end else if (state == S_BUSY) begin
      acc <= nxt;
      if (cnt == '0) begin
        res_q           <= nxt;
        flags_q[FLAG_Z] <= nxt == '0;
        flags_q[FLAG_C] <= !swap_q && |couts;
      end else cnt <= cnt - 1'b1;
    end
  end
endmodule

// File: tb/tb_vec_exec_iter.sv
// tb_vec_exec_iter: directed and randomized checks against a lane-array reference model
module tb_vec_exec_iter;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_ready, use_imm = 1'b0, swap_en = 1'b0;
  logic out_valid, out_ready = 1'b0;
  logic [2:0] op = '0, src = '0, dst = '0;
  logic [3:0] rep = '0;
  logic [7:0] imm = '0;
  logic [63:0] va = '0, vb = '0, res;
  logic [1:0] flags;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  vec_exec_iter dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .op_i(op), .vec_a_i(va), .vec_b_i(vb), .imm_i(imm), .use_imm_i(use_imm),
    .swap_en_i(swap_en), .swap_src_i(src), .swap_dst_i(dst), .rep_i(rep),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .res_o(res), .flags_o(flags)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: per-lane integer arithmetic, op applied rep+1 times; flags = {C, Z}
  function automatic void model(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b,
                                input int r, input bit sw, input int s, input int d,
                                output logic [63:0] y, output logic [1:0] f);
    int e[8], bb[8], c, t;
    for (int k = 0; k < 8; k++) begin
      e[k] = int'(a[k*8 +: 8]);
      bb[k] = int'(b[k*8 +: 8]);
    end
    c = 0;
    if (sw) begin
      t = e[s]; e[s] = e[d]; e[d] = t;
    end else
      for (int it = 0; it <= r; it++) begin
        c = 0;
        for (int k = 0; k < 8; k++)
          case (o)
            3'd0: begin t = e[k] + bb[k]; if (t > 255) c = 1; e[k] = t % 256; end
            3'd1: begin if (e[k] < bb[k]) c = 1; e[k] = (e[k] - bb[k] + 256) % 256; end
            3'd2: e[k] = e[k] & bb[k];
            3'd3: e[k] = e[k] | bb[k];
            3'd4: e[k] = e[k] ^ bb[k];
            3'd5: e[k] = (e[k] * 2) % 256;
            3'd6: e[k] = e[k] / 2;
            default: e[k] = (e[k] * 2) % 256 + e[k] / 128;
          endcase
      end
    for (int k = 0; k < 8; k++) y[k*8 +: 8] = 8'(e[k]);
    f = {c != 0, y == 64'd0};
  endfunction

  // Accept one op and wait for its result; leaves the result pending (out_ready low)
  task automatic issue(input string tag, input logic [2:0] o, input logic [63:0] a, input logic [63:0] b,
                       input logic [7:0] im, input bit ui, input bit sw, input logic [2:0] s,
                       input logic [2:0] d, input logic [3:0] r);
    logic [63:0] ey, eb;
    logic [1:0] ef;
    int n;
    @(negedge clk);
    check({tag, ".ready"}, 64'(in_ready), 64'd1);
    op = o; va = a; vb = b; imm = im; use_imm = ui; swap_en = sw; src = s; dst = d; rep = r;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1 n++;
    end
    eb = ui ? {8{im}} : b;
    model(o, a, eb, int'(r), sw, int'(s), int'(d), ey, ef);
    check({tag, ".latency"}, 64'(n), sw ? 64'd1 : 64'(r) + 64'd1);
    check({tag, ".res"}, res, ey);
    check({tag, ".flags"}, 64'(flags), 64'(ef));
  endtask

  task automatic drain(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check({tag, ".drained"}, 64'(out_valid), 64'd0);
    check({tag, ".ready_after"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [63:0] held;
    logic [1:0] held_f;
    int seen;
    #3;
    check("rst.ready", 64'(in_ready), 64'd0);
    check("rst.valid", 64'(out_valid), 64'd0);
    check("rst.res", res, 64'd0);
    check("rst.flags", 64'(flags), 64'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1 check("post_rst.ready", 64'(in_ready), 64'd1);

    issue("add_imm", 3'd0, 64'h0102030405060708, 64'h0, 8'h01, 1'b1, 1'b0, 3'd0, 3'd0, 4'd0);
    check("add_imm.exact", res, 64'h0203040506070809);
    drain("add_imm");
    issue("add_wrap", 3'd0, {8{8'hFE}}, 64'h0, 8'h01, 1'b1, 1'b0, 3'd0, 3'd0, 4'd1);
    check("add_wrap.exact", {res[63:2], flags}, {62'd0, 2'b11});
    drain("add_wrap");
    issue("sub_vec", 3'd1, 64'h0, {8{8'h01}}, 8'h00, 1'b0, 1'b0, 3'd0, 3'd0, 4'd0);
    check("sub_vec.exact", {res, 62'd0, flags}, {64'hFFFFFFFFFFFFFFFF, 62'd0, 2'b10});
    drain("sub_vec");
    issue("swap", 3'd0, 64'h0011223344556677, 64'h0, 8'h00, 1'b0, 1'b1, 3'd0, 3'd7, 4'd5);
    check("swap.exact", res, 64'h7711223344556600);
    drain("swap");
    issue("swap_same", 3'd4, 64'h0123456789ABCDEF, 64'h0, 8'h00, 1'b0, 1'b1, 3'd3, 3'd3, 4'd2);
    drain("swap_same");

    issue("bp", 3'd7, 64'h8001_4002_2004_1008, 64'h0, 8'h00, 1'b0, 1'b0, 3'd0, 3'd0, 4'd3);
    held = res;
    held_f = flags;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1; va = 64'(i) + 64'h55; op = 3'd0; rep = 4'd0; swap_en = 1'b0;
      @(posedge clk);
      #1;
      check("bp.res", res, held);
      check("bp.flags", 64'(flags), 64'(held_f));
      check("bp.valid", 64'(out_valid), 64'd1);
      check("bp.ready", 64'(in_ready), 64'd0);
    end
    @(negedge clk) in_valid = 1'b0;
    drain("bp");
    repeat (3) @(posedge clk);
    #1 check("bp.no_accept", 64'(out_valid), 64'd0);

    for (int t = 0; t < 40; t++) begin
      bit sw;
      sw = $urandom_range(3) == 0;
      issue("rand", 3'($urandom_range(7)), {$urandom, $urandom}, {$urandom, $urandom},
            8'($urandom), 1'($urandom), sw, 3'($urandom_range(7)), 3'($urandom_range(7)),
            4'($urandom_range(15)));
      drain("rand");
    end

    issue("pre_rst", 3'd3, 64'hF0F0_0000_1234_5678, 64'h0F0F_0000_0000_0001, 8'h00, 1'b0, 1'b0, 3'd0, 3'd0, 4'd0);
    drain("pre_rst");
    @(negedge clk);
    op = 3'd0; va = 64'h1111; use_imm = 1'b1; imm = 8'h01; swap_en = 1'b0; rep = 4'd15; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst.valid", 64'(out_valid), 64'd0);
    check("mid_rst.res", res, 64'd0);
    check("mid_rst.flags", 64'(flags), 64'd0);
    check("mid_rst.ready", 64'(in_ready), 64'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1 check("mid_rst.ready_after", 64'(in_ready), 64'd1);
    seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1 if (out_valid) seen++;
    end
    check("mid_rst.no_result", 64'(seen), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vec_exec_iter.md
# vec_exec_iter

Parametrised, multi-cycle vector execute unit for the encryption datapath. It takes one vector operation per handshake and applies a lane-wise ALU op or an element swap. The ALU op can be iterated up to 2^REP_BITS times, feeding each result back as operand A, which supports repeated cipher rounds. The result and flags are held registered behind a valid/ready handshake. It sits in the execute stage after operand fetch, in place of the single-cycle combinational vector ALU/swap path, and feeds writeback.

## Interface
- ELEM_SIZE, 8: bits per vector element
- VECT_SIZE, 8: elements per vector (power of two, ≥2)
- REP_BITS, 4: width of the repeat count
- IDX_BITS, $clog2(VECT_SIZE): width of the element index
- clk_i  in  1  clock; the block uses a single clock
- rst_i  in  1  reset, asynchronous, active-high
- in_valid_i  in  1  operation request
- in_ready_o  out  1  block can accept an operation
- op_i  in  3  ALU opcode
- vec_a_i  in  ELEM_SIZE*VECT_SIZE  operand A; element k occupies bits [k*ELEM_SIZE +: ELEM_SIZE]
- vec_b_i  in  ELEM_SIZE*VECT_SIZE  operand B
- imm_i  in  8  immediate value
- use_imm_i  in  1  use the immediate as B, broadcast to every lane
- swap_en_i  in  1  perform an element swap instead of the ALU op
- swap_src_i, swap_dst_i  in  IDX_BITS  element indices to exchange
- rep_i  in  REP_BITS  extra iterations; the op runs rep_i+1 times
- out_valid_o  out  1  result available
- out_ready_i  in  1  downstream accepts the result
- res_o  out  ELEM_SIZE*VECT_SIZE  result vector
- flags_o  out  2  [0] Z = all result elements zero; [1] C = carry/borrow out of any lane on the final iteration

## Operation
- Opcodes, applied per lane modulo 2^ELEM_SIZE: 0 ADD, 1 SUB (A−B), 2 AND, 3 OR, 4 XOR, 5 SHL1, 6 SHR1, 7 ROTL1.
  - Opcodes 5–7 ignore B.
- B is latched at accept and held for all iterations.
  - When use_imm_i=1, B is imm_i, zero-extended or truncated to ELEM_SIZE and replicated across all lanes.
- The C flag is the OR of the lane carry-outs (ADD) or borrows (SUB) on the final iteration only. It is 0 for every other opcode and for swaps.
- Swap: the result is A with elements src and dst exchanged.
  - The ALU is bypassed, rep_i is ignored, and exactly one iteration runs.
  - When src == dst, the result equals A.
- FSM states: IDLE, BUSY, DONE.
  - IDLE → BUSY on in_valid_i & in_ready_o. At that edge A, B, op, the swap fields are latched, and cnt is loaded with rep_i (0 for a swap).
  - In BUSY, every cycle acc ← f(acc, B). If cnt == 0, go to DONE with res_o and flags_o registered; otherwise cnt ← cnt−1.
  - In DONE, out_valid_o is 1. On out_ready_i, go to IDLE.
- in_ready_o = (state == IDLE). Requests presented in BUSY or DONE are not accepted and have no effect.

## Timing
- Reset (asynchronous, immediate):
  - state is IDLE; out_valid_o, res_o, flags_o and cnt are 0.
  - in_ready_o is 0 while rst_i is high and 1 from the first cycle after release.
- Latency: for an accept at edge E, out_valid_o rises at edge E + rep_i + 1 (E + 1 for a swap).
- res_o and flags_o are stable for as long as out_valid_o is high and out_ready_i is low.
- The output handshake completes at the edge where out_valid_o & out_ready_i are both high.
  - in_ready_o rises in the following cycle, so the minimum spacing between accepts is rep_i + 3 cycles.
- Reset during BUSY or DONE aborts the operation. No partial result is ever presented.

## Structure
- Package vec_exec_pkg holds:
  - an opcode enum (3 bits)
  - the FSM state enum
  - the flag bit index constants (FLAG_Z = 0, FLAG_C = 1)
- Sub-module vec_exec_lane: one ELEM_SIZE-wide combinational lane ALU (inputs a, b, op; outputs y, cout), generated VECT_SIZE times.
- The top level contains the FSM, the iteration counter, the operand and accumulator registers, the swap mux, and the flag reduction.

## Test plan
- ADD with immediate, no repeat: A = 0x0102030405060708, imm = 0x01, use_imm = 1, rep = 0 → one cycle later out_valid = 1, res = 0x0203040506070809, Z = 0, C = 0.
- Iterated ADD with wrap: all lanes of A = 0xFE, imm = 0x01, rep = 1 → out_valid two cycles after accept, res = 0x0000000000000000, Z = 1, C = 1 (carry from the final iteration).
- SUB with vector B: A = 0, B = all lanes 0x01, rep = 0 → res = 0xFFFFFFFFFFFFFFFF, Z = 0, C = 1.
- Swap ignores repeat: A = 0x0011223344556677, swap_en = 1, src = 0, dst = 7, rep = 5 → res = 0x7711223344556600 one cycle after accept, C = 0.
- Backpressure: hold out_ready_i low for 4 cycles while driving a new in_valid_i → res/flags unchanged, in_ready_o = 0, no new accept. Then raise out_ready_i → handshake completes, and in_ready_o = 1 on the next cycle.
- Reset mid-operation: rep = 15, assert rst_i 3 cycles after accept → out_valid_o, res_o and flags_o are 0 immediately. After release, in_ready_o = 1 and no result is emitted until a new accept.
